// File: rtl/max_unit5_pkg.sv
// FP16 helpers shared by the max-pool datapath: canonical NaN, field masks,
// NaN test and the total-order comparison key.
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_EXP_MASK = 16'h7C00;
  localparam logic [15:0] FP16_MAN_MASK = 16'h03FF;
  localparam logic [15:0] FP16_SIGN     = 16'h8000;

  function automatic logic is_nan(input logic [15:0] v);
    return ((v & FP16_EXP_MASK) == FP16_EXP_MASK) && ((v & FP16_MAN_MASK) != '0);
  endfunction

  // Unsigned compare of these keys orders -Inf .. -0, +0 .. +Inf.
  function automatic logic [15:0] total_key(input logic [15:0] v);
    return v[15] ? ~v : (v | FP16_SIGN);
  endfunction

endpackage

// File: rtl/max_unit5_if.sv
// Window-in / max-out bus of the 5x5 max-pool unit.
interface max_unit5_if #(parameter int DATA_WIDTH = 16);

  logic                     in_valid;
  logic [DATA_WIDTH*25-1:0] x;
  logic                     out_valid;
  logic [DATA_WIDTH-1:0]    max_out;

  modport master (output in_valid, output x, input out_valid, input max_out);
  modport slave  (input in_valid, input x, output out_valid, output max_out);

endinterface

// File: rtl/max_unit5_max2.sv
// Combinational FP16 two-input max: NaN loses, two NaNs give the canonical
// quiet NaN, equal keys keep operand a (the lower index).
module fp16_max2
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  logic aNan;
  logic bNan;

  always_comb begin
    aNan = is_nan(a);
    bNan = is_nan(b);
    y    = a;
    if (aNan && bNan)
      y = FP16_QNAN;
    else if (aNan)
      y = b;
    else if (bNan)
      y = a;
    else if (total_key(b) > total_key(a))
      y = b;
  end

endmodule

// File: rtl/max_unit5.sv
// Pipelined 5x5 FP16 max-pool: 25 -> 13 -> 7 -> 4 -> 2 -> 1 comparator tree,
// the odd element passing through at each level.
module max_unit5
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  max_unit5_if.slave bus
);

  logic [DATA_WIDTH-1:0] win   [25];
  logic [DATA_WIDTH-1:0] lvl1D [13];
  logic [DATA_WIDTH-1:0] lvl1Q [13];
  logic [DATA_WIDTH-1:0] lvl2D [7];
  logic [DATA_WIDTH-1:0] lvl2Q [7];
  logic [DATA_WIDTH-1:0] lvl3D [4];
  logic [DATA_WIDTH-1:0] lvl3Q [4];
  logic [DATA_WIDTH-1:0] lvl4D [2];
  logic [DATA_WIDTH-1:0] lvl4Q [2];
  logic [DATA_WIDTH-1:0] lvl5D;
  logic [DATA_WIDTH-1:0] maxQ;
  logic [5:0]            validQ;

  for (genvar i = 0; i < 12; i++) begin : genLvl1
    fp16_max2 uMax (.a(win[2*i]), .b(win[2*i+1]), .y(lvl1D[i]));
  end
  assign lvl1D[12] = win[24];

  for (genvar i = 0; i < 6; i++) begin : genLvl2
    fp16_max2 uMax (.a(lvl1Q[2*i]), .b(lvl1Q[2*i+1]), .y(lvl2D[i]));
  end
  assign lvl2D[6] = lvl1Q[12];

  for (genvar i = 0; i < 3; i++) begin : genLvl3
    fp16_max2 uMax (.a(lvl2Q[2*i]), .b(lvl2Q[2*i+1]), .y(lvl3D[i]));
  end
  assign lvl3D[3] = lvl2Q[6];

  for (genvar i = 0; i < 2; i++) begin : genLvl4
    fp16_max2 uMax (.a(lvl3Q[2*i]), .b(lvl3Q[2*i+1]), .y(lvl4D[i]));
  end

  fp16_max2 uLvl5 (.a(lvl4Q[0]), .b(lvl4Q[1]), .y(lvl5D));

  // Window capture register plus one register per tree level: a window
  // sampled at edge N reaches max_out after edge N+5.
  always_ff @(posedge clk) begin
    if (rst) begin
      validQ <= '0;
      for (int unsigned i = 0; i < 25; i++) win[i]   <= '0;
      for (int unsigned i = 0; i < 13; i++) lvl1Q[i] <= '0;
      for (int unsigned i = 0; i < 7; i++)  lvl2Q[i] <= '0;
      for (int unsigned i = 0; i < 4; i++)  lvl3Q[i] <= '0;
      for (int unsigned i = 0; i < 2; i++)  lvl4Q[i] <= '0;
      maxQ   <= '0;
    end else begin
      validQ <= {validQ[4:0], bus.in_valid};
      for (int unsigned i = 0; i < 25; i++) win[i]   <= bus.x[DATA_WIDTH*i +: DATA_WIDTH];
      for (int unsigned i = 0; i < 13; i++) lvl1Q[i] <= lvl1D[i];
      for (int unsigned i = 0; i < 7; i++)  lvl2Q[i] <= lvl2D[i];
      for (int unsigned i = 0; i < 4; i++)  lvl3Q[i] <= lvl3D[i];
      for (int unsigned i = 0; i < 2; i++)  lvl4Q[i] <= lvl4D[i];
      maxQ   <= lvl5D;
    end
  end

  assign bus.out_valid = validQ[5];
  assign bus.max_out   = maxQ;

endmodule

// File: tb/tb_max_unit5.sv
// Self-checking bench for max_unit5: directed window table, latency/bubble/reset
// sequences and random windows checked against a per-edge history model.
module tb_max_unit5;

  typedef logic [399:0] win_t;
  typedef struct {
    win_t        x;
    logic [15:0] exp;
    string       name;
  } vec_t;

  localparam int H = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  max_unit5_if #(.DATA_WIDTH(16)) bus ();
  max_unit5 #(.DATA_WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [15:0] curExp  = 16'h0000;
  string       curName = "idle";
  logic        checkOn = 1'b1;

  logic        vH [H];
  logic        rH [H];
  logic [15:0] eH [H];
  string       nH [H];
  int          edgeN = 0;

  // Reference: maximum over non-NaN elements by total order, else canonical NaN.
  function automatic logic [15:0] refMax(input win_t w);
    logic [15:0] e, best, bestKey, k;
    bit found;
    found = 0; best = 16'h7E00; bestKey = 16'h0000;
    for (int i = 0; i < 25; i++) begin
      e = w[16*i +: 16];
      if (e[14:10] == 5'h1F && e[9:0] != 10'd0) continue;
      k = e[15] ? 16'hFFFF - e : 16'h8000 + {1'b0, e[14:0]};
      if (!found || k > bestKey) begin
        found = 1; best = e; bestKey = k;
      end
    end
    return best;
  endfunction

  function automatic win_t fillWin(input logic [15:0] v);
    win_t w;
    for (int i = 0; i < 25; i++) w[16*i +: 16] = v;
    return w;
  endfunction

  function automatic win_t randWin();
    win_t w;
    logic [15:0] e;
    bit allNan;
    allNan = ($urandom_range(0, 19) == 0);
    for (int i = 0; i < 25; i++) begin
      if (allNan) e = 16'h7C00 | 16'($urandom_range(1, 1023)) | (16'($urandom_range(0, 1)) << 15);
      else begin
        case ($urandom_range(0, 7))
          0: e = 16'h7C00;
          1: e = 16'hFC00;
          2: e = 16'h0000;
          3: e = 16'h8000;
          4: e = 16'h7C00 | 16'($urandom_range(1, 1023));
          default: e = 16'($urandom);
        endcase
      end
      w[16*i +: 16] = e;
    end
    return w;
  endfunction

  // History of what was sampled at each edge; checked #1 after the edge.
  always @(posedge clk) begin
    int E;
    bit anyRst;
    if (edgeN >= H) begin
      $display("FAIL history: edge count %0d exceeds limit %0d", edgeN, H);
      $fatal(1);
    end
    vH[edgeN] = bus.in_valid;
    rH[edgeN] = rst;
    eH[edgeN] = curExp;
    nH[edgeN] = curName;
    E = edgeN;
    edgeN++;
    #1;
    if (checkOn) begin
      anyRst = 0;
      for (int k = 0; k <= 5; k++)
        if (E - k < 0 || rH[E-k]) anyRst = 1;
      if (anyRst) begin
        tests++;
        if (bus.out_valid !== 1'b0 || bus.max_out !== 16'h0000) begin
          fails++;
          $display("FAIL reset_flush edge %0d: out_valid=%0b max_out=%h, required 0 / 0000",
                   E, bus.out_valid, bus.max_out);
        end
      end else begin
        tests++;
        if (bus.out_valid !== vH[E-5]) begin
          fails++;
          $display("FAIL out_valid[%s] edge %0d: got %0b, required %0b",
                   nH[E-5], E, bus.out_valid, vH[E-5]);
        end else if (vH[E-5]) begin
          tests++;
          if (bus.max_out !== eH[E-5]) begin
            fails++;
            $display("FAIL max_out[%s] edge %0d: got %h, required %h",
                     nH[E-5], E, bus.max_out, eH[E-5]);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input win_t w, input logic [15:0] e, input string n);
    bus.in_valid = v;
    bus.x        = w;
    curExp       = e;
    curName      = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, randWin(), 16'h0000, "idle");
  endtask

  vec_t vecs[10];

  initial begin
    win_t w;
    int lat, zeros;
    logic [15:0] negs[4];
    logic [15:0] lowNeg[5];

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.x = '0;

    negs   = '{16'hC500, 16'hC400, 16'hC200, 16'hC000};
    lowNeg = '{16'hBC00, 16'hC000, 16'hC200, 16'hC400, 16'hC500};

    w = fillWin(16'h4000); w[16*4 +: 16] = 16'h4200;
    vecs[0] = '{w, 16'h4200, "one_larger"};
    w = fillWin(16'h4200); w[0 +: 16] = 16'h4500;
    for (int i = 17; i < 25; i++) w[16*i +: 16] = lowNeg[(i - 17) % 5];
    vecs[1] = '{w, 16'h4500, "first_elem"};
    for (int i = 0; i < 24; i++) w[16*i +: 16] = negs[i % 4];
    w[16*24 +: 16] = 16'hBC00;
    vecs[2] = '{w, 16'hBC00, "neg_passthru"};
    w = fillWin(16'hFC00); w[16*7 +: 16] = 16'h8000;
    vecs[3] = '{w, 16'h8000, "neg_zero"};
    w[16*3 +: 16] = 16'h0000;
    vecs[4] = '{w, 16'h0000, "pos_zero"};
    w = fillWin(16'h7C00); w[16*12 +: 16] = 16'h7D01;
    vecs[5] = '{w, 16'h7C00, "nan_vs_inf"};
    vecs[6] = '{fillWin(16'h7E01), 16'h7E00, "all_nan"};
    vecs[7] = '{fillWin(16'hFC00), 16'hFC00, "all_neg_inf"};
    w = fillWin(16'hFC01); w[16*24 +: 16] = 16'h3C00;
    vecs[8] = '{w, 16'h3C00, "nan_last_real"};
    w = fillWin(16'h3555); w[16*20 +: 16] = 16'h3556;
    vecs[9] = '{w, 16'h3556, "near_equal"};

    repeat (3) drive(1'b0, '0, 16'h0000, "reset");
    rst = 1'b0;
    idle(2);

    // Directed table, back to back.
    for (int i = 0; i < 10; i++) drive(1'b1, vecs[i].x, vecs[i].exp, vecs[i].name);
    idle(7);

    // Latency of a single window.
    drive(1'b1, vecs[0].x, vecs[0].exp, "latency");
    bus.in_valid = 1'b0; curName = "idle";
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat != 5) begin
      fails++;
      $display("FAIL latency: got %0d cycles, required 5", lat);
    end
    idle(6);

    // Bubble pattern 1,0,1.
    drive(1'b1, vecs[1].x, vecs[1].exp, "bubble_a");
    drive(1'b0, vecs[2].x, 16'h0000, "bubble_gap");
    drive(1'b1, vecs[3].x, vecs[3].exp, "bubble_b");
    idle(7);

    // Ten distinct random windows streamed, then reset mid-stream.
    for (int i = 0; i < 10; i++) begin
      w = randWin(); drive(1'b1, w, refMax(w), "stream");
    end
    for (int i = 0; i < 3; i++) begin
      w = randWin(); drive(1'b1, w, refMax(w), "pre_reset");
    end
    rst = 1'b1;
    w = randWin(); drive(1'b1, w, refMax(w), "at_reset");
    rst = 1'b0;
    zeros = (bus.out_valid === 1'b0 && bus.max_out === 16'h0000) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      w = randWin(); drive(1'b1, w, refMax(w), "post_reset");
      if (bus.out_valid === 1'b0 && bus.max_out === 16'h0000) zeros++;
    end
    tests++;
    if (zeros != 5) begin
      fails++;
      $display("FAIL reset_gap: got %0d flushed cycles, required 5", zeros);
    end

    // Random windows with random bubbles.
    for (int i = 0; i < 300; i++) begin
      w = randWin();
      if ($urandom_range(0, 3) != 0) drive(1'b1, w, refMax(w), "random");
      else drive(1'b0, w, 16'h0000, "random_gap");
    end
    idle(8);

    checkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
